// File: rtl/skip_subtractor_seq_if.sv
// Handshake bundle for the block-serial skip subtractor: operand side and result side.
interface skip_subtractor_seq_if #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
);
    localparam int NB = WIDTH / BLOCK;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic [NB-1:0]    skip_mask;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, skip_mask
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, skip_mask
    );
endinterface

// File: rtl/skip_subtractor_seq.sv
// Sequential subtractor computing a - b - bin one BLOCK-bit slice per cycle,
// flagging the slices whose borrow-out came through the all-propagate skip path.
module skip_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    skip_subtractor_seq_if.slave  bus
);
    // WIDTH is expected to be a whole multiple of BLOCK.
    localparam int NB = WIDTH / BLOCK;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [NB-1:0]    r_skip;
    logic [KW-1:0]    r_k;

    logic             w_accept;
    logic             w_last;
    int               w_base;
    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [BLOCK-1:0] w_a_blk;
    logic [BLOCK-1:0] w_b_blk;
    logic [BLOCK-1:0] w_d_blk;
    logic             w_p_i;
    logic             w_g_i;
    logic             w_ripple;
    logic             w_g_blk;
    logic             w_p_all;
    logic             w_skip;
    logic             w_blk_bout;

    assign w_accept = (r_state == IDLE) & bus.in_valid;
    assign w_last   = (r_k == KW'(NB - 1));
    assign w_base   = int'(r_k) * BLOCK;
    assign w_a_sh   = r_a >> w_base;
    assign w_b_sh   = r_b >> w_base;
    assign w_a_blk  = w_a_sh[BLOCK-1:0];
    assign w_b_blk  = w_b_sh[BLOCK-1:0];

    // Per-block slice: ripple borrow for the difference bits, a separate ripple
    // of generate alone (borrow-in 0), and the all-propagate term for the skip.
    always_comb begin
        w_ripple = r_borrow;
        w_g_blk  = 1'b0;
        w_p_all  = 1'b1;
        w_d_blk  = '0;
        w_p_i    = 1'b0;
        w_g_i    = 1'b0;
        for (int i = 0; i < BLOCK; i++) begin
            w_p_i      = ~(w_a_blk[i] ^ w_b_blk[i]);
            w_g_i      = ~w_a_blk[i] & w_b_blk[i];
            w_d_blk[i] = w_a_blk[i] ^ w_b_blk[i] ^ w_ripple;
            w_ripple   = w_g_i | (w_p_i & w_ripple);
            w_g_blk    = w_g_i | (w_p_i & w_g_blk);
            w_p_all    = w_p_all & w_p_i;
        end
        w_skip     = w_p_all & r_borrow;
        w_blk_bout = w_g_blk | w_skip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = BUSY;
            BUSY:    if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    // Unprocessed slices of r_diff stay zero, so each new slice is simply OR-ed in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_skip   <= '0;
            r_k      <= '0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_skip   <= '0;
            r_k      <= '0;
        end else if (r_state == BUSY) begin
            r_diff   <= r_diff | (WIDTH'(w_d_blk) << w_base);
            r_skip   <= r_skip | (NB'(w_skip) << r_k);
            r_borrow <= w_blk_bout;
            if (w_last) begin
                r_bout <= w_blk_bout;
            end else begin
                r_k    <= r_k + KW'(1);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.skip_mask = r_skip;
endmodule

// File: tb/tb_skip_subtractor_seq.sv
// Scoreboard bench for skip_subtractor_seq: directed corner vectors, backpressure,
// mid-operation reset, and randomized operands against an arithmetic reference.
module tb_skip_subtractor_seq;
    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NB    = WIDTH / BLOCK;

    typedef struct packed {
        logic [15:0] diff;
        logic        bout;
        logic [3:0]  skip;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];
    exp_t mon_e;

    skip_subtractor_seq_if #(.WIDTH(WIDTH), .BLOCK(BLOCK)) bus ();

    skip_subtractor_seq #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic; the borrow into slice k is whether the
    // low k*BLOCK bits of a are smaller than those of b plus bin.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        exp_t r;
        int   ai, bi, ci, base, am, bm;
        ai     = int'(a);
        bi     = int'(b);
        ci     = int'(bin);
        r.diff = 16'((ai - bi - ci) & 32'hFFFF);
        r.bout = (ai < bi + ci);
        for (int k = 0; k < NB; k++) begin
            base      = k * BLOCK;
            am        = ai % (1 << base);
            bm        = bi % (1 << base);
            r.skip[k] = (((ai >> base) & 15) == ((bi >> base) & 15)) && (am < bm + ci);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; 1: random backpressure; 2: hold off 5 cycles, poke in_valid, then pulse ready
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tbin,
                         input logic use_exp, input exp_t e_in, input int mode);
        int   n;
        logic done;
        exp_t e;
        e = use_exp ? e_in : model(ta, tbv, tbin);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("wait_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tbv;
        bus.bin      = tbin;
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.bin      = 1'($urandom);
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(NB));
        if (mode == 2) begin
            for (int c = 0; c < 5; c++) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'($urandom);
                check("hold_diff", 32'(bus.diff), 32'(e.diff));
                check("hold_bout", 32'(bus.bout), 32'(e.bout));
                check("hold_skip", 32'(bus.skip_mask), 32'(e.skip));
                check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                check("hold_out_valid", 32'(bus.out_valid), 32'd1);
                tick();
            end
            bus.in_valid = 1'b0;
        end
        done = 1'b0;
        n    = 0;
        while (!done && n < 100) begin
            bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            done = bus.out_ready;
            n++;
        end
        bus.out_ready = 1'b0;
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got diff=%0h with no pending expectation", bus.diff);
            end else begin
                mon_e = sb.pop_front();
                check("sb_diff", 32'(bus.diff), 32'(mon_e.diff));
                check("sb_bout", 32'(bus.bout), 32'(mon_e.bout));
                check("sb_skip", 32'(bus.skip_mask), 32'(mon_e.skip));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        int          sel;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
        check("rst_skip", 32'(bus.skip_mask), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b1, 4'b1110}, 0);
        do_op(16'h1234, 16'h1234, 1'b1, 1'b1, '{16'hFFFF, 1'b1, 4'b1111}, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b0, 4'b0110}, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b1, 4'b1110}, 2);
        repeat (3) begin
            check("idle_no_output", 32'(bus.out_valid), 32'd0);
            tick();
        end

        // Abort an operation in its second BUSY cycle.
        bus.in_valid = 1'b1;
        bus.a        = 16'h0000;
        bus.b        = 16'h0001;
        bus.bin      = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_diff", 32'(bus.diff), 32'd0);
        check("abort_skip", 32'(bus.skip_mask), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h0F0F, 1'b0, 1'b1, '{16'hF1F0, 1'b1, 4'b1000}, 0);

        for (int t = 0; t < 1000; t++) begin
            sel = $urandom_range(0, 7);
            ra  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
            sel = $urandom_range(0, 7);
            rb  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : (sel == 2) ? ra : 16'($urandom);
            do_op(ra, rb, 1'($urandom), 1'b0, '0, 1);
        end

        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
